cond_sum_seq_ctrl: RTL

Sequencing controller that performs NIBBLES×4-bit add/subtract by iterating the external 4-bit conditional-sum adder one nibble per cycle, LSB first, with a registered ripple carry between nibbles. It accepts operands over a valid/ready handshake, drives the adder's X/Y/Cin, and captures its Sum/C_out. It returns the full-width result, carry-out and signed overflow over a second valid/ready handshake.

---
 rtl/cond_sum_seq_ctrl_if.sv | 38 +++
 rtl/cond_sum_seq_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/cond_sum_seq_ctrl_if.sv
// Bundle of the operand, adder and result channels of cond_sum_seq_ctrl.
// master is the controller side, slave is the requester/adder side.
interface cond_sum_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_in;
  logic         sub;
  logic [3:0]   add_x;
  logic [3:0]   add_y;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;

  modport master (
    input  start_valid, op_a, op_b, cin_in, sub,
    input  add_sum, add_cout, res_ready,
    output start_ready, add_x, add_y, add_cin,
    output res_valid, res_sum, res_cout, res_ovf
  );

  modport slave (
    output start_valid, op_a, op_b, cin_in, sub,
    output add_sum, add_cout, res_ready,
    input  start_ready, add_x, add_y, add_cin,
    input  res_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/cond_sum_seq_ctrl.sv
// Nibble-serial add/subtract sequencer around an external 4-bit
// conditional-sum adder, LSB nibble first, with registered ripple carry.
module cond_sum_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  cond_sum_seq_ctrl_if.master bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           ovf_q;
  logic           last;
  logic           in_run;

  assign last   = (idx_q == IW'(NIBBLES - 1));
  assign in_run = rst_n && (state == RUN);

  // Outputs are forced low while reset is held, whatever the state.
  assign bus.start_ready = rst_n && (state == IDLE);
  assign bus.res_valid   = rst_n && (state == DONE);
  assign bus.res_sum     = rst_n ? sum_q : '0;
  assign bus.res_cout    = rst_n && cout_q;
  assign bus.res_ovf     = rst_n && ovf_q;
  assign bus.add_x       = in_run ? a_q[4*idx_q +: 4] : 4'h0;
  assign bus.add_y       = in_run ? b_q[4*idx_q +: 4] : 4'h0;
  assign bus.add_cin     = in_run && carry_q;

  // Sequencer: latch operands, step one nibble per cycle, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.op_a;
            b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.sub | bus.cin_in;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= bus.add_sum;
          carry_q             <= bus.add_cout;
          idx_q               <= idx_q + IW'(1);
          if (last) begin
            idx_q  <= '0;
            cout_q <= bus.add_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) &&
                      (bus.add_sum[3] != a_q[W-1]);
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
